// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: PC/instruction path to the instruction memory and the
// IF/ID valid/ready handshake toward decode.
interface instr_fetch_unit_if;
    logic [31:0] IF_PC;
    logic [31:0] IF_instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    modport master (
        output IF_PC,
        input  IF_instr_in,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        input  IF_PC,
        output IF_instr_in,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: presents the PC to a combinational instruction memory
// and captures the returned word into an IF/ID register with valid/ready output.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd80,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_fetch_unit_if.master      bus,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    halted,
    output logic                    misalign_err,
    output logic [CNT_W-1:0]        fetch_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam int unsigned PC_W = 32;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [31:0]        instr_q, instr_d;
    logic [PC_W-1:0]    opc_q, opc_d;
    logic [PC_W-1:0]    opc4_q, opc4_d;
    logic               halted_q, halted_d;
    logic               mis_q, mis_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load;
    logic               handshake;
    logic [PC_W-1:0]    pc_plus4;

    assign load      = !valid_q || bus.out_ready;
    assign handshake = valid_q && bus.out_ready;
    assign pc_plus4  = pc_q + PC_W'(4);

    // State and IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            opc_q    <= '0;
            opc4_q   <= '0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            opc4_q   <= opc4_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: redirect beats stall and halt; a handshake in a redirect cycle still counts
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        opc_d    = opc_q;
        opc4_d   = opc4_q;
        halted_d = halted_q;
        mis_d    = mis_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
        cnt_d    = (handshake && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            valid_d  = 1'b0;
            state_d  = RUN;
            halted_d = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (load) begin
                        if (pc_q >= PC_LIMIT) begin
                            valid_d  = 1'b0;
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            instr_d = bus.IF_instr_in;
                            opc_d   = pc_q;
                            opc4_d  = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign bus.IF_PC        = pc_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_pc       = opc_q;
    assign bus.out_pc_plus4 = opc4_q;
    assign halted           = halted_q;
    assign misalign_err     = mis_q;
    assign fetch_count      = cnt_q;

endmodule
